dma_wr_packer: RTL and testbench
================================

// Module: dma_wr_packer
// PURPOSE
//  Write-back stage between memory_controller and the DMA write channel. Reads
//  consecutive 32-bit words from local memory, packs WORDS_PER_CL words into
//  one cache line and pushes each line into the DMA write FIFO, respecting full.
//  Started by the AFU with a base word address and a line count; pulses done.
// PARAMETERS
//  CL_WIDTH     512  cache-line width in bits (dma.wr_data width)
//  WORD_WIDTH   32   memory word width in bits; CL_WIDTH % WORD_WIDTH == 0
//  ADDR_WIDTH   28   memory word-address width (matches memory_controller)
//  COUNT_WIDTH  17   width of line-count input
// PORTS
//  clk          in   1            clock
//  rst          in   1            synchronous reset, active high
//  start        in   1            1-cycle pulse: begin transfer (sampled in IDLE only)
//  base_addr    in   ADDR_WIDTH   first memory word address, latched on start
//  num_lines    in   COUNT_WIDTH  cache lines to transfer, latched on start
//  mem_en       out  1            memory read request, 1-cycle pulse
//  mem_addr     out  ADDR_WIDTH   word address of request, valid with mem_en
//  mem_valid    in   1            read data valid (variable latency >=1 cycle)
//  mem_data     in   WORD_WIDTH   read data, valid with mem_valid
//  dma_full     in   1            DMA write FIFO full
//  dma_wr_en    out  1            push dma_wr_data into DMA write FIFO
//  dma_wr_data  out  CL_WIDTH     packed cache line
//  busy         out  1            high from cycle after start until done
//  done         out  1            1-cycle pulse after last line pushed
// BEHAVIOUR
//  - Reset: state=IDLE; mem_en, dma_wr_en, busy, done = 0; mem_addr,
//    dma_wr_data, word index, line counter = 0. Reset mid-transfer aborts
//    immediately; a later mem_valid from the aborted request is ignored.
//  - WORDS_PER_CL = CL_WIDTH/WORD_WIDTH (16 default); word index 0..15.
//  - FSM: IDLE -> (start & num_lines!=0) REQ; (start & num_lines==0) DONE.
//    REQ: mem_en=1, mem_addr=cur_addr for one cycle -> WAIT.
//    WAIT: on mem_valid write mem_data to bits [idx*WORD_WIDTH +: WORD_WIDTH]
//      (word 0 in LSBs); cur_addr+=1; idx==last ? PUSH : (idx+=1, REQ).
//    PUSH: if !dma_full, dma_wr_en=1 for exactly that cycle, idx=0,
//      lines_left-=1; lines_left==1 ? DONE : REQ. If dma_full, hold, no push.
//    DONE: done=1 one cycle, busy=0 -> IDLE.
//  - Exactly one outstanding memory request; mem_valid outside WAIT ignored.
//  - dma_wr_data holds the completed line stable throughout PUSH; registered.
//  - cur_addr increments modulo 2^ADDR_WIDTH (wraps to 0, no error).
//  - start while busy is ignored; base_addr/num_lines changes after latch ignored.
//  - Latency per line with 1-cycle memory: 16*(REQ+WAIT)=32 cycles + 1 PUSH.
//  - busy rises the cycle after start is sampled; done and busy never both high.
// TESTING
//  1 Reset: hold rst 3 cycles mid-transfer -> all outputs 0, IDLE, next start works.
//  2 start, base=0x100, lines=1, mem returns data=addr, latency 1 -> 16 reads
//    0x100..0x10F, one dma_wr_en, dma_wr_data word i = 0x100+i, done 33 cyc later.
//  3 lines=3, dma_full forced high 10 cycles at first PUSH -> no push while
//    full, data stable, exactly 3 pushes total, addresses contiguous 0x000..0x02F.
//  4 lines=0 -> no mem_en, no dma_wr_en, done pulse the cycle after start.
//  5 base=0xFFFFFF8, lines=1 -> addresses 0xFFFFFF8..0xFFFFFFF then 0x0..0x7.
//  6 Random mem latency 1-5 cycles, spurious mem_valid in REQ/PUSH, start pulses
//    while busy -> spurious inputs ignored, packed data matches model.

Source files
------------

// File: rtl/dma_wr_packer.sv
// Write-back packer: fetches WORDS_PER_CL consecutive memory words per cache line,
// packs them (word 0 in the LSBs) and pushes each line into the DMA write FIFO.
module dma_wr_packer #(
  parameter int CL_WIDTH    = 512,
  parameter int WORD_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 28,
  parameter int COUNT_WIDTH = 17
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [ADDR_WIDTH-1:0]  base_addr,
  input  logic [COUNT_WIDTH-1:0] num_lines,
  output logic                   mem_en,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  input  logic                   mem_valid,
  input  logic [WORD_WIDTH-1:0]  mem_data,
  input  logic                   dma_full,
  output logic                   dma_wr_en,
  output logic [CL_WIDTH-1:0]    dma_wr_data,
  output logic                   busy,
  output logic                   done,
  output logic [2:0]             dbg_state
);

  localparam int WORDS_PER_CL = CL_WIDTH / WORD_WIDTH;
  localparam int IDX_W        = (WORDS_PER_CL > 1) ? $clog2(WORDS_PER_CL) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_CL - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_PUSH = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t                 r_state;
  logic [ADDR_WIDTH-1:0]  r_cur_addr;
  logic [IDX_W-1:0]       r_idx;
  logic [COUNT_WIDTH-1:0] r_lines_left;
  logic [CL_WIDTH-1:0]    r_line;
  logic                   r_mem_en;
  logic [ADDR_WIDTH-1:0]  r_mem_addr;
  logic                   r_busy;
  logic                   r_done;
  logic                   w_push;

  // Handshake: a line transfers on any cycle where dma_wr_en is high; dma_wr_en is
  // only raised in PUSH while dma_full is low, and dma_wr_data is held until then.
  assign w_push = (r_state == S_PUSH) && !dma_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cur_addr   <= '0;
      r_idx        <= '0;
      r_lines_left <= '0;
      r_line       <= '0;
      r_mem_en     <= 1'b0;
      r_mem_addr   <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_mem_en <= 1'b0;
      r_done   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_cur_addr   <= base_addr;
            r_lines_left <= num_lines;
            r_idx        <= '0;
            if (num_lines != '0) begin
              r_state    <= S_REQ;
              r_busy     <= 1'b1;
              r_mem_en   <= 1'b1;
              r_mem_addr <= base_addr;
            end else begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end
          end
        end
        S_REQ: begin
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (mem_valid) begin
            r_line[r_idx*WORD_WIDTH +: WORD_WIDTH] <= mem_data;
            r_cur_addr <= r_cur_addr + ADDR_WIDTH'(1);
            if (r_idx == LAST_IDX) begin
              r_state <= S_PUSH;
            end else begin
              r_idx      <= r_idx + IDX_W'(1);
              r_state    <= S_REQ;
              r_mem_en   <= 1'b1;
              r_mem_addr <= r_cur_addr + ADDR_WIDTH'(1);
            end
          end
        end
        S_PUSH: begin
          if (w_push) begin
            r_idx        <= '0;
            r_lines_left <= r_lines_left - COUNT_WIDTH'(1);
            if (r_lines_left == COUNT_WIDTH'(1)) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state    <= S_REQ;
              r_mem_en   <= 1'b1;
              r_mem_addr <= r_cur_addr;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign mem_en      = r_mem_en;
  assign mem_addr    = r_mem_addr;
  assign dma_wr_en   = w_push;
  assign dma_wr_data = r_line;
  assign busy        = r_busy;
  assign done        = r_done;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_dma_wr_packer.sv
// Bench for dma_wr_packer: table of transfers, a memory responder with variable
// latency, and a scoreboard of expected addresses and packed lines.
module tb_dma_wr_packer;

  localparam int CL_W   = 512;
  localparam int WORD_W = 32;
  localparam int ADDR_W = 28;
  localparam int CNT_W  = 17;
  localparam int WPC    = CL_W / WORD_W;
  localparam int NVEC   = 7;

  logic              clk       = 1'b0;
  logic              rst       = 1'b1;
  logic              start     = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [CNT_W-1:0]  num_lines = '0;
  logic              mem_en;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_valid = 1'b0;
  logic [WORD_W-1:0] mem_data  = '0;
  logic              dma_full  = 1'b0;
  logic              dma_wr_en;
  logic [CL_W-1:0]   dma_wr_data;
  logic              busy;
  logic              done;
  logic [2:0]        dbg_state;

  dma_wr_packer #(
    .CL_WIDTH(CL_W), .WORD_WIDTH(WORD_W), .ADDR_WIDTH(ADDR_W), .COUNT_WIDTH(CNT_W)
  ) u_dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .num_lines(num_lines),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_valid(mem_valid), .mem_data(mem_data),
    .dma_full(dma_full), .dma_wr_en(dma_wr_en), .dma_wr_data(dma_wr_data),
    .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] base;
    logic [CNT_W-1:0]  lines;
    int                full_cyc;
    int                lat_max;
    bit                chaos;
    logic [WORD_W-1:0] pat;
  } vec_t;

  vec_t vecs [NVEC];

  logic [CL_W-1:0]   exp_q[$];
  logic [ADDR_W-1:0] exp_addr_q[$];
  int total = 0;
  int bad   = 0;

  int                cfg_lat_max  = 1;
  int                cfg_full_cyc = 0;
  bit                cfg_chaos    = 1'b0;
  logic [WORD_W-1:0] cfg_pat      = '0;
  int                xfer_id      = 0;
  int                poke_req     = 0;
  int                push_cnt     = 0;

  task automatic chk(input string name, input logic [CL_W-1:0] act, input logic [CL_W-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic fail_evt(input string name, input string what);
    total++;
    bad++;
    $display("FAIL %s: %s", name, what);
  endtask

  function automatic logic [WORD_W-1:0] data_of(input logic [ADDR_W-1:0] a);
    return WORD_W'(a) ^ cfg_pat;
  endfunction

  // Memory responder and dma_full driver, updated just after each rising edge.
  int                pend_cnt  = 0;
  logic [ADDR_W-1:0] pend_addr = '0;
  bit                pend_arm  = 1'b0;
  int                seen_id   = 0;
  int                words     = 0;
  int                full_left = 0;
  bit                stall_chk = 1'b0;
  int                poke_done = 0;

  always @(posedge clk) begin
    #1;
    if (rst) begin
      pend_cnt  = 0;
      mem_valid = 1'b0;
      dma_full  = 1'b0;
      full_left = 0;
      stall_chk = 1'b0;
    end else begin
      mem_valid = 1'b0;
      mem_data  = $urandom;
      if (full_left > 0) begin
        full_left--;
        stall_chk = (full_left > 0);
        dma_full  = (full_left > 0);
      end else if (cfg_chaos) begin
        dma_full = ($urandom_range(0, 3) == 0);
      end else begin
        dma_full = 1'b0;
      end
      if (pend_cnt > 0) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          mem_valid = 1'b1;
          mem_data  = data_of(pend_addr);
          if (pend_arm) begin
            dma_full  = 1'b1;
            full_left = cfg_full_cyc + 1;
            stall_chk = 1'b0;
          end
        end
      end else if (poke_done != poke_req) begin
        poke_done = poke_req;
        mem_valid = 1'b1;
      end else if (cfg_chaos && $urandom_range(0, 2) == 0) begin
        mem_valid = 1'b1;
      end
      if (mem_en) begin
        chk("one_outstanding", pend_cnt != 0, 1'b0);
        if (seen_id != xfer_id) begin
          seen_id = xfer_id;
          words   = 0;
        end
        words++;
        pend_addr = mem_addr;
        pend_cnt  = $urandom_range(1, cfg_lat_max);
        pend_arm  = (words == WPC) && (cfg_full_cyc > 0);
      end
    end
  end

  // Scoreboard: requests and pushed lines are compared on the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (done) chk("busy_with_done", busy, 1'b0);
      if (dma_full) chk("push_while_full", dma_wr_en, 1'b0);
      if (stall_chk && exp_q.size() != 0) chk("stall_data", dma_wr_data, exp_q[0]);
      if (mem_en) begin
        if (exp_addr_q.size() == 0) fail_evt("mem_en_extra", $sformatf("addr %0h none expected", mem_addr));
        else chk("mem_addr", mem_addr, exp_addr_q.pop_front());
      end
      if (dma_wr_en) begin
        push_cnt++;
        if (exp_q.size() == 0) fail_evt("push_extra", "dma_wr_en with no line expected");
        else chk("line_data", dma_wr_data, exp_q.pop_front());
      end
    end
  end

  task automatic start_vec(input vec_t v);
    logic [CL_W-1:0]   line;
    logic [ADDR_W-1:0] a;
    cfg_lat_max  = v.lat_max;
    cfg_full_cyc = v.full_cyc;
    cfg_chaos    = v.chaos;
    cfg_pat      = v.pat;
    xfer_id++;
    for (int l = 0; l < int'(v.lines); l++) begin
      line = '0;
      for (int w = 0; w < WPC; w++) begin
        a = v.base + ADDR_W'(l * WPC + w);
        exp_addr_q.push_back(a);
        line[w*WORD_W +: WORD_W] = data_of(a);
      end
      exp_q.push_back(line);
    end
    @(negedge clk);
    base_addr = v.base;
    num_lines = v.lines;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    base_addr = ADDR_W'($urandom);
    num_lines = CNT_W'($urandom);
    chk("busy_rise", busy, v.lines != '0);
  endtask

  task automatic wait_done(input vec_t v);
    int cyc;
    int p0;
    int exp_cyc;
    p0  = push_cnt;
    cyc = 1;
    while (!done && cyc < 20000) begin
      if (v.chaos && busy && $urandom_range(0, 15) == 0) begin
        start     = 1'b1;
        base_addr = ADDR_W'($urandom);
        num_lines = CNT_W'($urandom);
        @(negedge clk);
        start = 1'b0;
      end else begin
        @(negedge clk);
      end
      cyc++;
    end
    if (!done) begin
      fail_evt("done_timeout", $sformatf("no done after %0d cycles", cyc));
    end else if (v.lat_max == 1 && !v.chaos) begin
      exp_cyc = int'(v.lines) * 33 + 1 + ((v.lines != '0) ? v.full_cyc : 0);
      chk("done_cycle", cyc, exp_cyc);
    end
    @(negedge clk);
    chk("done_pulse", done, 1'b0);
    chk("busy_idle", busy, 1'b0);
    chk("push_count", push_cnt - p0, int'(v.lines));
    chk("lines_left", exp_q.size(), 0);
    chk("addrs_left", exp_addr_q.size(), 0);
  endtask

  initial begin
    vecs[0] = '{base: 28'h0000100, lines: 17'd1, full_cyc: 0,  lat_max: 1, chaos: 1'b0, pat: 32'h0};
    vecs[1] = '{base: 28'h0000000, lines: 17'd3, full_cyc: 10, lat_max: 1, chaos: 1'b0, pat: 32'h0};
    vecs[2] = '{base: 28'h0000040, lines: 17'd0, full_cyc: 0,  lat_max: 1, chaos: 1'b0, pat: 32'h0};
    vecs[3] = '{base: 28'hFFFFFF8, lines: 17'd1, full_cyc: 0,  lat_max: 1, chaos: 1'b0, pat: 32'h0};
    for (int i = 4; i < NVEC; i++) begin
      vecs[i].base     = ADDR_W'($urandom);
      vecs[i].lines    = CNT_W'($urandom_range(1, 3));
      vecs[i].full_cyc = 0;
      vecs[i].lat_max  = 5;
      vecs[i].chaos    = 1'b1;
      vecs[i].pat      = $urandom;
    end

    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_mem_en", mem_en, 1'b0);
    chk("rst_mem_addr", mem_addr, 1'b0);
    chk("rst_wr_en", dma_wr_en, 1'b0);
    chk("rst_wr_data", dma_wr_data, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_state", dbg_state, 3'd0);
    rst = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      start_vec(vecs[i]);
      wait_done(vecs[i]);
    end

    // Reset in the middle of a multi-line transfer, then a stray mem_valid in IDLE.
    start_vec(vecs[1]);
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_mem_en", mem_en, 1'b0);
    chk("midrst_mem_addr", mem_addr, 1'b0);
    chk("midrst_wr_data", dma_wr_data, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_done", done, 1'b0);
    chk("midrst_state", dbg_state, 3'd0);
    exp_q.delete();
    exp_addr_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    poke_req++;
    repeat (4) @(negedge clk);
    chk("post_rst_state", dbg_state, 3'd0);
    chk("post_rst_busy", busy, 1'b0);
    start_vec(vecs[0]);
    wait_done(vecs[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
